// File: rtl/timer_access_master.sv
// 64-bit access engine for the 32-bit machine-timer port: coherent hi-lo-hi
// reads of mtime and interrupt-safe three-store writes of mtimecmp.
module timer_access_master #(
    parameter logic [31:0] TIMER_BASE = 32'hFFFF0000,
    parameter int unsigned MAX_RETRY  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RETRY);

    localparam logic [31:0] A_MTIME_LO = TIMER_BASE;
    localparam logic [31:0] A_MTIME_HI = TIMER_BASE + 32'd4;
    localparam logic [31:0] A_CMP_LO   = TIMER_BASE + 32'd8;
    localparam logic [31:0] A_CMP_HI   = TIMER_BASE + 32'd12;

    typedef enum logic [2:0] {
        IDLE,
        RD_HI1,
        RD_LO,
        RD_HI2,
        WR_HIMAX,
        WR_LO,
        WR_HI,
        RESP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } bus_drv_t;

    state_t        state, state_nxt;
    bus_drv_t      drv;
    logic [31:0]   hi_a;
    logic [31:0]   lo;
    logic [63:0]   wdata_q;
    logic [CW-1:0] retry_cnt;
    logic [CW-1:0] retry_inc;
    logic          accept;
    logic          hi_match;

    assign accept    = req_valid && req_ready;
    assign hi_match  = (bus_rdata == hi_a);
    assign retry_inc = retry_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = req_write ? WR_HIMAX : RD_HI1;
            RD_HI1:   state_nxt = RD_LO;
            RD_LO:    state_nxt = RD_HI2;
            RD_HI2: begin
                if (hi_match || retry_inc == MAX_CNT) state_nxt = RESP;
                else                                  state_nxt = RD_LO;
            end
            WR_HIMAX: state_nxt = WR_LO;
            WR_LO:    state_nxt = WR_HI;
            WR_HI:    state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Moore bus decode; the high compare word is parked at all-ones first so
    // the intermediate {old_hi, new_lo} value can never match mtime.
    always_comb begin
        drv       = '{addr: TIMER_BASE, wdata: 32'h0, we: 1'b0};
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:     req_ready = 1'b1;
            RD_HI1:   drv.addr  = A_MTIME_HI;
            RD_LO:    drv.addr  = A_MTIME_LO;
            RD_HI2:   drv.addr  = A_MTIME_HI;
            WR_HIMAX: drv       = '{addr: A_CMP_HI, wdata: 32'hFFFF_FFFF, we: 1'b1};
            WR_LO:    drv       = '{addr: A_CMP_LO, wdata: wdata_q[31:0],  we: 1'b1};
            WR_HI:    drv       = '{addr: A_CMP_HI, wdata: wdata_q[63:32], we: 1'b1};
            RESP:     rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    assign bus_addr  = drv.addr;
    assign bus_wdata = drv.wdata;
    assign bus_we    = drv.we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_a      <= 32'h0;
            lo        <= 32'h0;
            wdata_q   <= 64'h0;
            retry_cnt <= '0;
            rsp_rdata <= 64'h0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wdata_q   <= req_wdata;
                        retry_cnt <= '0;
                    end
                end
                RD_HI1: hi_a <= bus_rdata;
                RD_LO:  lo   <= bus_rdata;
                RD_HI2: begin
                    if (hi_match) begin
                        rsp_rdata <= {hi_a, lo};
                        rsp_error <= 1'b0;
                    end else begin
                        // the fresh hi word becomes the reference for the retry
                        retry_cnt <= retry_inc;
                        hi_a      <= bus_rdata;
                        if (retry_inc == MAX_CNT) begin
                            rsp_rdata <= 64'h0;
                            rsp_error <= 1'b1;
                        end
                    end
                end
                WR_HI:   rsp_error <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_access_master.sv
// Randomized bench for timer_access_master: scripted timer model for retry
// behaviour plus a free-running mtime/mtimecmp model for integration.
module tb_timer_access_master;

    localparam logic [31:0] BASE  = 32'hFFFF0000;
    localparam logic [31:0] A_LO  = 32'hFFFF0000;
    localparam logic [31:0] A_HI  = 32'hFFFF0004;
    localparam logic [31:0] A_CLO = 32'hFFFF0008;
    localparam logic [31:0] A_CHI = 32'hFFFF000C;
    localparam int MAXR = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_wdata = 64'h0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_access_master #(.TIMER_BASE(BASE), .MAX_RETRY(MAXR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_rdata(bus_rdata)
    );

    // Timer model: scripted tables indexed by hi reads so far, or a real timer.
    logic        real_mode = 1'b0;
    logic [31:0] hi_tab [0:15];
    logic [31:0] lo_tab [0:15];
    logic [3:0]  hi_cnt = 4'd0;
    logic [63:0] mtime = 64'h0;
    logic [63:0] mtimecmp = '1;
    logic [31:0] wr_addr_log [0:7];
    logic [31:0] wr_data_log [0:7];
    logic [3:0]  wr_n = 4'd0;
    logic        irq;

    assign irq = (mtime >= mtimecmp);

    always @(posedge clk) begin
        mtime <= mtime + 64'd1;
        if (req_valid && req_ready) begin
            hi_cnt <= 4'd0;
            wr_n   <= 4'd0;
        end else begin
            if (bus_addr == A_HI && !bus_we && hi_cnt != 4'd15) hi_cnt <= hi_cnt + 4'd1;
            if (bus_we && wr_n < 4'd8) begin
                wr_addr_log[wr_n[2:0]] <= bus_addr;
                wr_data_log[wr_n[2:0]] <= bus_wdata;
                wr_n <= wr_n + 4'd1;
            end
        end
        if (real_mode && bus_we) begin
            if (bus_addr == A_CLO) mtimecmp[31:0]  <= bus_wdata;
            if (bus_addr == A_CHI) mtimecmp[63:32] <= bus_wdata;
        end
    end

    always_comb begin
        bus_rdata = 32'h0;
        if (real_mode) begin
            case (bus_addr)
                A_LO:    bus_rdata = mtime[31:0];
                A_HI:    bus_rdata = mtime[63:32];
                A_CLO:   bus_rdata = mtimecmp[31:0];
                A_CHI:   bus_rdata = mtimecmp[63:32];
                default: bus_rdata = 32'h0;
            endcase
        end else if (bus_addr == A_HI) begin
            bus_rdata = hi_tab[hi_cnt];
        end else if (bus_addr == A_LO) begin
            bus_rdata = lo_tab[hi_cnt];
        end
    end

    // Reference: walk the hi/lo sequence with the hi-lo-hi rule.
    function automatic void model_read(output logic [63:0] d, output logic e, output int lat);
        logic [31:0] h;
        int mism;
        h = hi_tab[0];
        mism = 0;
        d = 64'h0; e = 1'b0; lat = 0;
        for (int i = 1; i < 16; i++) begin
            if (hi_tab[i[3:0]] == h) begin
                d = {h, lo_tab[i[3:0]]}; e = 1'b0; lat = 4 + 2 * mism;
                return;
            end
            mism++;
            if (mism == MAXR) begin
                d = 64'h0; e = 1'b1; lat = 4 + 2 * (mism - 1);
                return;
            end
            h = hi_tab[i[3:0]];
        end
    endfunction

    // Issue one request and wait for rsp_valid; lat counts cycles after the accept edge.
    task automatic run_req(input logic wr, input logic [63:0] wd, input bit no_wait,
                           output int lat, output logic [31:0] a1, output logic [31:0] a2,
                           output logic [31:0] a3);
        if (!no_wait) @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = {$urandom, $urandom};
        lat = 0; a1 = 32'h0; a2 = 32'h0; a3 = 32'h0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1) a1 = bus_addr;
            if (k == 2) a2 = bus_addr;
            if (k == 3) a3 = bus_addr;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error, bus_addr, bus_wdata, bus_we} !==
            {1'b1, 1'b0, 64'h0, 1'b0, BASE, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL %s: ready=%b vld=%b rdata=%h err=%b addr=%h wdata=%h we=%b, required reset values",
                     tag, req_ready, rsp_valid, rsp_rdata, rsp_error, bus_addr, bus_wdata, bus_we);
        end
    endtask

    task automatic check_read(input string tag, input logic [63:0] ed, input logic ee,
                              input int elat, input bit chk_addr);
        int lat;
        logic [31:0] a1, a2, a3;
        run_req(1'b0, {$urandom, $urandom}, 1'b0, lat, a1, a2, a3);
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", tag, lat, elat);
        end
        checks++;
        if (rsp_rdata !== ed || rsp_error !== ee) begin
            errors++;
            $display("FAIL %s data: got %h err=%b, required %h err=%b", tag, rsp_rdata, rsp_error, ed, ee);
        end
        if (chk_addr) begin
            checks++;
            if ({a1, a2, a3} !== {A_HI, A_LO, A_HI}) begin
                errors++;
                $display("FAIL %s addrs: got %h %h %h, required %h %h %h", tag, a1, a2, a3, A_HI, A_LO, A_HI);
            end
        end
    endtask

    task automatic check_write(input string tag, input logic [63:0] wd);
        int lat;
        logic [31:0] a1, a2, a3;
        logic [63:0] prev;
        prev = rsp_rdata;
        run_req(1'b1, wd, 1'b0, lat, a1, a2, a3);
        checks++;
        if (lat !== 4 || rsp_error !== 1'b0 || rsp_rdata !== prev) begin
            errors++;
            $display("FAIL %s rsp: lat=%0d err=%b rdata=%h, required lat=4 err=0 rdata=%h",
                     tag, lat, rsp_error, rsp_rdata, prev);
        end
        checks++;
        if (wr_n !== 4'd3 ||
            {wr_addr_log[0], wr_data_log[0]} !== {A_CHI, 32'hFFFF_FFFF} ||
            {wr_addr_log[1], wr_data_log[1]} !== {A_CLO, wd[31:0]} ||
            {wr_addr_log[2], wr_data_log[2]} !== {A_CHI, wd[63:32]}) begin
            errors++;
            $display("FAIL %s stores: n=%0d (%h,%h) (%h,%h) (%h,%h), required (%h,FFFFFFFF) (%h,%h) (%h,%h)",
                     tag, wr_n, wr_addr_log[0], wr_data_log[0], wr_addr_log[1], wr_data_log[1],
                     wr_addr_log[2], wr_data_log[2], A_CHI, A_CLO, wd[31:0], A_CHI, wd[63:32]);
        end
    endtask

    task automatic fill_tables(input logic [31:0] h, input logic [31:0] l);
        for (int i = 0; i < 16; i++) begin
            hi_tab[i] = h;
            lo_tab[i] = l;
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_basic();
        fill_tables(32'h1, 32'h10);
        check_read("read_basic", 64'h0000000100000010, 1'b0, 4, 1'b1);
    endtask

    task automatic test_rollover();
        fill_tables(32'h1, 32'h3);
        hi_tab[0] = 32'h0;
        lo_tab[1] = 32'h2;
        check_read("rollover", 64'h0000000100000003, 1'b0, 6, 1'b0);
    endtask

    task automatic test_retry_exhaust();
        for (int i = 0; i < 16; i++) begin
            hi_tab[i] = i[0] ? 32'h5 : 32'h4;
            lo_tab[i] = $urandom;
        end
        check_read("retry_exhaust", 64'h0, 1'b1, 10, 1'b0);
    endtask

    task automatic test_write_basic();
        check_write("write_basic", 64'h0000000200001000);
    endtask

    task automatic test_random_reads();
        logic [63:0] ed;
        logic ee;
        int elat;
        for (int n = 0; n < 40; n++) begin
            hi_tab[0] = $urandom;
            for (int i = 0; i < 16; i++) begin
                if (i > 0) hi_tab[i] = ($urandom_range(0, 2) == 0) ? hi_tab[i-1] + 32'd1 : hi_tab[i-1];
                lo_tab[i] = $urandom;
            end
            model_read(ed, ee, elat);
            check_read("random_read", ed, ee, elat, 1'b1);
        end
    endtask

    task automatic test_random_writes();
        for (int n = 0; n < 20; n++) check_write("random_write", {$urandom, $urandom});
    endtask

    // req_valid held high: accepts land every 5 cycles, responses one cycle before.
    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_wdata = {$urandom, $urandom};
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== (k % 5 == 4) || req_ready !== (k % 5 == 0)) begin
                errors++;
                $display("FAIL back_to_back k=%0d: vld=%b ready=%b, required vld=%b ready=%b",
                         k, rsp_valid, req_ready, (k % 5 == 4), (k % 5 == 0));
            end
            if (k == 14) req_valid = 1'b0;
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 64'h0000000200001000;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("reset_midop");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_midop rsp_valid: got %b, required 0", rsp_valid);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release ready: got %b, required 1", req_ready);
        end
        fill_tables(32'hA5, 32'h5A);
        check_read("read_after_reset", 64'h000000A50000005A, 1'b0, 4, 1'b1);
    endtask

    task automatic test_integration();
        int lat;
        logic [31:0] a1, a2, a3;
        logic [63:0] c, tgt, rise;
        real_mode = 1'b1;
        @(negedge clk);
        c = mtime;
        run_req(1'b0, 64'h0, 1'b1, lat, a1, a2, a3);
        checks++;
        if (lat != 4 || rsp_error !== 1'b0 || rsp_rdata < c + 64'd1 || rsp_rdata > c + 64'd3) begin
            errors++;
            $display("FAIL int_read: got %h lat=%0d err=%b, required in [%h,%h] lat=4",
                     rsp_rdata, lat, rsp_error, c + 64'd1, c + 64'd3);
        end
        @(negedge clk);
        tgt = mtime + 64'd20;
        run_req(1'b1, tgt, 1'b1, lat, a1, a2, a3);
        checks++;
        if (irq !== 1'b0 || mtimecmp !== tgt) begin
            errors++;
            $display("FAIL int_write: irq=%b cmp=%h, required irq=0 cmp=%h", irq, mtimecmp, tgt);
        end
        rise = 64'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (irq) begin
                rise = mtime;
                break;
            end
        end
        checks++;
        if (rise !== tgt) begin
            errors++;
            $display("FAIL int_irq_rise: mtime at rise %h, required %h", rise, tgt);
        end
        real_mode = 1'b0;
    endtask

    initial begin
        fill_tables(32'h0, 32'h0);
        test_reset();
        test_read_basic();
        test_rollover();
        test_retry_exhaust();
        test_write_basic();
        test_random_reads();
        test_random_writes();
        test_back_to_back();
        test_reset_midop();
        test_integration();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
